exe_pipe_ctrl: RTL and testbench
================================

Name: exe_pipe_ctrl

Overview:
- Sequencing controller for the execute stage of the 5-stage ARM pipeline.
- Owns the architectural status register (NZCV) that feeds the EXE ALU carry-in and the ID condition check.
- Generates branch-taken and flush when EXE resolves a branch.
- Freezes the pipeline while a load/store in EXE waits on the multi-cycle SRAM, with a timeout.

Parameters:
- TIMEOUT, 16: max cycles in ACCESS waiting for sram_ready before abort.
- CNT_W, 16: width of stall performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- EXE_valid  input  1  EXE pipeline register holds a real instruction (not bubble)
- S  input  1  EXE instruction updates status
- B  input  1  EXE instruction is a taken branch (condition already passed in ID)
- MEM_R_EN  input  1  EXE instruction is a load
- MEM_W_EN  input  1  EXE instruction is a store
- status_alu  input  4  {N,Z,C,V} from EXE ALU this cycle
- sram_ready  input  1  memory completed current access
- status  output  4  {N,Z,C,V} architectural status register
- mem_start  output  1  one-cycle pulse launching SRAM access
- freeze  output  1  hold PC, IF/ID, ID/EXE registers; insert bubble into EXE/MEM
- Branch_taken  output  1  select branch address at PC mux
- flush  output  1  clear IF/ID and ID/EXE contents
- mem_error  output  1  one-cycle pulse on access timeout
- stall_cnt  output  CNT_W  total cycles freeze was high since reset, saturating

Behaviour:
- Reset values: state=IDLE, status=4'b0000, wait_cnt=0, stall_cnt=0. All pulse outputs (mem_start, freeze, Branch_taken, flush, mem_error) are 0 while rst=1.
- mem = EXE_valid & (MEM_R_EN | MEM_W_EN).
- FSM states: IDLE, ACCESS.
- IDLE, mem=1:
  - mem_start=1 and freeze=1 (combinational, same cycle).
  - Next state ACCESS; wait_cnt<=0.
- IDLE, mem=0: freeze=0; stay IDLE.
- ACCESS, sram_ready=0 and wait_cnt<TIMEOUT-1:
  - freeze=1; wait_cnt<=wait_cnt+1; stay ACCESS.
- ACCESS, sram_ready=1:
  - freeze=0 this cycle, so the pipeline advances at this edge.
  - Next state IDLE.
  - sram_ready has priority over timeout when both occur in the same cycle.
- ACCESS, sram_ready=0 and wait_cnt==TIMEOUT-1:
  - mem_error=1 for one cycle; freeze=0; next state IDLE.
- sram_ready is ignored in IDLE. Minimum EXE occupancy of a memory op is 2 cycles; N cycles in ACCESS gives N+1 cycles total.
- mem_start never asserts in ACCESS.
- Branch_taken = EXE_valid & B & ~freeze; flush = Branch_taken.
- A branch co-resident with a memory op resolves only in the cycle the freeze is released.
- Status update: at the rising edge, if EXE_valid & S & ~freeze, status<=status_alu; otherwise status holds.
  - An S instruction that is stalled updates exactly once, on its release cycle.
  - A timed-out memory op with S set still updates on its release cycle.
- stall_cnt increments at every edge where freeze=1; it saturates at all-ones.
- Bubble (EXE_valid=0): no mem_start, no branch, no status change, regardless of the other inputs.
- rst asserted mid-ACCESS: FSM returns to IDLE next edge, freeze drops, and no mem_error is emitted.

Test Plan:
- Reset, then ADDS with status_alu=4'b0110, S=1, valid=1 for one cycle -> status=4'b0110 after that edge; mem_start/freeze stay 0.
- LDR in EXE, sram_ready raised on 3rd ACCESS cycle -> mem_start high cycle 0 only, freeze high cycles 0-2 and low cycle 3, FSM IDLE cycle 4, stall_cnt=3.
- Taken branch, valid=1, B=1, not frozen -> Branch_taken=1 and flush=1 for exactly that cycle; next bubble (valid=0, B=1) gives 0.
- STR with sram_ready never asserted, TIMEOUT=4 -> freeze high 4 cycles (IDLE + 3 ACCESS), mem_error pulse on the 4th, then IDLE.
  - Repeat with sram_ready=1 exactly on the 4th cycle -> no mem_error.
- LDR with S=1, status_alu=4'b1001, held frozen 2 ACCESS cycles -> status unchanged until the release edge, then 4'b1001 once.
- rst asserted during ACCESS with freeze high -> next cycle freeze=0, status=0, stall_cnt=0, no mem_error.
  - A following memory op restarts with mem_start.

Source files
------------

// File: rtl/exe_pipe_ctrl.sv
// Execute-stage sequencing controller: NZCV register, branch resolve/flush,
// and the SRAM-access freeze FSM with a wait timeout.
module exe_pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE_valid,
  input  logic             S,
  input  logic             B,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic [3:0]       status_alu,
  input  logic             sram_ready,
  output logic [3:0]       status,
  output logic             mem_start,
  output logic             freeze,
  output logic             Branch_taken,
  output logic             flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic          mem;

  assign mem = EXE_valid & (MEM_R_EN | MEM_W_EN);

  always_comb begin
    state_nx  = state;
    wait_nx   = wait_cnt;
    mem_start = 1'b0;
    freeze    = 1'b0;
    mem_error = 1'b0;
    case (state)
      IDLE: begin
        if (mem) begin
          mem_start = 1'b1;
          freeze    = 1'b1;
          state_nx  = ACCESS;
          wait_nx   = '0;
        end
      end
      ACCESS: begin
        // ready wins over timeout in the same cycle
        if (sram_ready) begin
          state_nx = IDLE;
        end else if (wait_cnt == LAST) begin
          mem_error = 1'b1;
          state_nx  = IDLE;
        end else begin
          freeze  = 1'b1;
          wait_nx = wait_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      mem_start = 1'b0;
      freeze    = 1'b0;
      mem_error = 1'b0;
    end
  end

  assign Branch_taken = EXE_valid & B & ~freeze & ~rst;
  assign flush        = Branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      status    <= 4'b0000;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      // a stalled S instruction commits flags only on its release cycle
      if (EXE_valid & S & ~freeze) status <= status_alu;
      if (freeze && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// Bench for exe_pipe_ctrl: directed vector table plus randomized run against
// a cycle-count reference model.
module tb_exe_pipe_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, EXE_valid, S, B, MEM_R_EN, MEM_W_EN, sram_ready;
  logic [3:0]    status_alu, status;
  logic          mem_start, freeze, Branch_taken, flush, mem_error;
  logic [CW-1:0] stall_cnt;

  exe_pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .EXE_valid(EXE_valid), .S(S), .B(B),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .status_alu(status_alu),
    .sram_ready(sram_ready), .status(status), .mem_start(mem_start),
    .freeze(freeze), .Branch_taken(Branch_taken), .flush(flush),
    .mem_error(mem_error), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v, s, b, r, w;
    logic [3:0] alu;
    logic rdy;
    logic ms, fz, bt, err;
    logic [3:0] st;
    int sc;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  // reference model: acc = cycles already spent in the access phase, -1 when none
  int       acc;
  logic [3:0] m_st;
  int       m_sc;

  function automatic vec_t mk(input logic rs, v, s, b, r, w, input logic [3:0] alu,
                              input logic rdy, input logic ms, fz, bt, err,
                              input logic [3:0] st, input int sc);
    vec_t t;
    t.rst = rs; t.v = v; t.s = s; t.b = b; t.r = r; t.w = w; t.alu = alu; t.rdy = rdy;
    t.ms = ms; t.fz = fz; t.bt = bt; t.err = err; t.st = st; t.sc = sc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_comb(input vec_t t, output logic ms, fz, bt, err);
    logic memop;
    memop = t.v & (t.r | t.w);
    ms = 1'b0; fz = 1'b0; err = 1'b0;
    if (!t.rst) begin
      if (acc < 0) begin
        ms = memop;
        fz = memop;
      end else if (!t.rdy) begin
        if (acc == TO - 1) err = 1'b1;
        else fz = 1'b1;
      end
    end
    bt = !t.rst & t.v & t.b & !fz;
  endtask

  task automatic mdl_edge(input vec_t t, input logic fz);
    if (t.rst) begin
      acc = -1; m_st = 4'b0000; m_sc = 0;
    end else begin
      if (fz && m_sc < SMAX) m_sc++;
      if (t.v && t.s && !fz) m_st = t.alu;
      if (acc < 0) begin
        if (t.v && (t.r || t.w)) acc = 0;
      end else if (t.rdy || acc == TO - 1) acc = -1;
      else acc++;
    end
  endtask

  task automatic step(input vec_t t, input bit use_tbl);
    logic ms, fz, bt, err;
    rst = t.rst; EXE_valid = t.v; S = t.s; B = t.b; MEM_R_EN = t.r; MEM_W_EN = t.w;
    status_alu = t.alu; sram_ready = t.rdy;
    #2;
    mdl_comb(t, ms, fz, bt, err);
    chk("mem_start", mem_start, ms);
    chk("freeze", freeze, fz);
    chk("Branch_taken", Branch_taken, bt);
    chk("flush", flush, bt);
    chk("mem_error", mem_error, err);
    if (use_tbl) begin
      chk("tbl_mem_start", mem_start, t.ms);
      chk("tbl_freeze", freeze, t.fz);
      chk("tbl_branch", Branch_taken, t.bt);
      chk("tbl_mem_error", mem_error, t.err);
    end
    @(posedge clk);
    mdl_edge(t, fz);
    #1;
    chk("status", status, m_st);
    chk("stall_cnt", stall_cnt, m_sc);
    if (use_tbl) begin
      chk("tbl_status", status, t.st);
      chk("tbl_stall_cnt", stall_cnt, t.sc);
    end
  endtask

  initial begin
    vec_t t;
    acc = -1; m_st = 4'b0000; m_sc = 0;
    rst = 1'b1; EXE_valid = 1'b0; S = 1'b0; B = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    status_alu = 4'b0000; sram_ready = 1'b0;

    //            rst v s b r w alu      rdy  ms fz bt er st       sc
    tbl.push_back(mk(1, 1,1,1,1,0, 4'b1111, 0,  0, 0, 0, 0, 4'b0000, 0));  // reset
    tbl.push_back(mk(0, 1,1,0,0,0, 4'b0110, 0,  0, 0, 0, 0, 4'b0110, 0));  // ADDS
    tbl.push_back(mk(0, 1,0,1,0,0, 4'b0000, 0,  0, 0, 1, 0, 4'b0110, 0));  // branch
    tbl.push_back(mk(0, 0,1,1,0,0, 4'b1111, 0,  0, 0, 0, 0, 4'b0110, 0));  // bubble
    tbl.push_back(mk(0, 1,1,0,1,0, 4'b1001, 1,  1, 1, 0, 0, 4'b0110, 1));  // LDRS, ready ignored
    tbl.push_back(mk(0, 1,1,0,1,0, 4'b1001, 0,  0, 1, 0, 0, 4'b0110, 2));
    tbl.push_back(mk(0, 1,1,0,1,0, 4'b1001, 0,  0, 1, 0, 0, 4'b0110, 3));
    tbl.push_back(mk(0, 1,1,0,1,0, 4'b1001, 1,  0, 0, 0, 0, 4'b1001, 3));  // release
    tbl.push_back(mk(0, 0,0,0,0,0, 4'b0000, 0,  0, 0, 0, 0, 4'b1001, 3));
    tbl.push_back(mk(0, 1,0,1,0,1, 4'b0000, 0,  1, 1, 0, 0, 4'b1001, 4));  // STR + branch, timeout
    tbl.push_back(mk(0, 1,0,1,0,1, 4'b0000, 0,  0, 1, 0, 0, 4'b1001, 5));
    tbl.push_back(mk(0, 1,0,1,0,1, 4'b0000, 0,  0, 1, 0, 0, 4'b1001, 6));
    tbl.push_back(mk(0, 1,0,1,0,1, 4'b0000, 0,  0, 1, 0, 0, 4'b1001, 7));
    tbl.push_back(mk(0, 1,0,1,0,1, 4'b0000, 0,  0, 0, 1, 1, 4'b1001, 7));  // abort
    tbl.push_back(mk(0, 0,0,0,0,0, 4'b0000, 0,  0, 0, 0, 0, 4'b1001, 7));
    tbl.push_back(mk(0, 1,0,0,0,1, 4'b0000, 0,  1, 1, 0, 0, 4'b1001, 8));  // STR, ready at last slot
    tbl.push_back(mk(0, 1,0,0,0,1, 4'b0000, 0,  0, 1, 0, 0, 4'b1001, 9));
    tbl.push_back(mk(0, 1,0,0,0,1, 4'b0000, 0,  0, 1, 0, 0, 4'b1001, 10));
    tbl.push_back(mk(0, 1,0,0,0,1, 4'b0000, 0,  0, 1, 0, 0, 4'b1001, 11));
    tbl.push_back(mk(0, 1,0,0,0,1, 4'b0000, 1,  0, 0, 0, 0, 4'b1001, 11));
    tbl.push_back(mk(0, 0,0,0,0,0, 4'b0000, 0,  0, 0, 0, 0, 4'b1001, 11));
    tbl.push_back(mk(0, 1,0,0,0,1, 4'b0000, 0,  1, 1, 0, 0, 4'b1001, 12)); // reset mid-access
    tbl.push_back(mk(0, 1,0,0,0,1, 4'b0000, 0,  0, 1, 0, 0, 4'b1001, 13));
    tbl.push_back(mk(1, 1,0,0,0,1, 4'b0000, 0,  0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0,0,0,0,0, 4'b0000, 0,  0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 1,0,0,1,0, 4'b0000, 0,  1, 1, 0, 0, 4'b0000, 1));  // restart
    tbl.push_back(mk(0, 1,0,0,1,0, 4'b0000, 1,  0, 0, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(0, 0,0,0,0,0, 4'b0000, 0,  0, 0, 0, 0, 4'b0000, 1));

    @(posedge clk); #1;
    foreach (tbl[i]) step(tbl[i], 1'b1);

    for (int i = 0; i < 3000; i++) begin
      t = mk(($urandom_range(0, 127) == 0), $urandom_range(0, 7) != 0, $urandom_range(0, 1),
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0,
             0, 0, 0, 0, 4'b0000, 0);
      step(t, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
